// File: rtl/caf_lag_correlator.sv
// caf_lag_correlator: captures CAP_LEN complex samples, correlates them against a
// REF_LEN reference at every lag, and reports the peak |corr|^2 and its lag.
// Optional feature: define CAF_ALL_LAGS_EN to stream every lag result before the peak beat.
`timescale 1ns/1ps
module caf_lag_correlator #(
  parameter int IQ_W      = 8,
  parameter int CAP_LEN   = 64,
  parameter int REF_LEN   = 16,
  parameter int MAG_SHIFT = 0,
  parameter int ONESHOT   = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [2*IQ_W-1:0]                          m_axis_tdata,
  input  logic                                       m_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic                                       ref_wen,
  input  logic [(REF_LEN>1?$clog2(REF_LEN):1)-1:0]   ref_waddr,
  input  logic [2*IQ_W-1:0]                          ref_wdata,
  output logic                                       ref_wready,
  input  logic                                       arm,
  output logic [31:0]                                s_axis_tdata,
  output logic                                       s_axis_tvalid,
  output logic                                       s_axis_tlast,
  input  logic                                       m_axis_tready,
  output logic                                       busy
);

  localparam int NUM_LAGS = CAP_LEN - REF_LEN + 1;
  localparam int CA_W = (CAP_LEN > 1) ? $clog2(CAP_LEN) : 1;
  localparam int RA_W = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
  localparam int CW   = $clog2(REF_LEN + 4);
  localparam int DW   = 2 * IQ_W;
  localparam int PW   = 2 * IQ_W + 1;
  localparam int AW   = PW + $clog2(REF_LEN);
  localparam int MW   = 2 * AW;
  localparam logic [CW-1:0]   CNT_ISSUE   = CW'(REF_LEN);
  localparam logic [CW-1:0]   CNT_ACC_END = CW'(REF_LEN + 1);
  localparam logic [CW-1:0]   CNT_MAG     = CW'(REF_LEN + 2);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(REF_LEN + 3);
  localparam logic [15:0]     LAG_LAST    = 16'(NUM_LAGS - 1);
  localparam logic [CA_W-1:0] CAP_LAST    = CA_W'(CAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, CORRELATE, REPORT, HALT} state_t;

  state_t state, next_state;

  logic [DW-1:0]          cap_mem [CAP_LEN];
  logic [DW-1:0]          ref_mem [REF_LEN];
  logic [CA_W-1:0]        cap_waddr, cap_raddr;
  logic [RA_W-1:0]        ref_raddr;
  logic [DW-1:0]          cap_rdata, ref_rdata;
  logic                   beat, ref_we, handshake, last_beat, lag_done;
  logic [CW-1:0]          cnt;
  logic [15:0]            lag, peak_lag;
  logic signed [IQ_W-1:0] ci, cq, ri, rq;
  logic signed [DW-1:0]   p_ii, p_qq, p_qi, p_iq;
  logic signed [PW-1:0]   prod_re, prod_im;
  logic signed [AW-1:0]   acc_re, acc_im;
  logic signed [MW-1:0]   sq_re, sq_im;
  logic [MW-1:0]          mag_next, mag, peak_mag;

  function automatic logic [15:0] sat16(input logic [MW-1:0] v);
    logic [MW-1:0] s;
    s = v >> MAG_SHIFT;
    if (|s[MW-1:16]) return 16'hFFFF;
    return s[15:0];
  endfunction

  assign beat      = m_axis_tvalid & s_axis_tready;
  assign ref_we    = ref_wen & ref_wready;
  assign handshake = s_axis_tvalid & m_axis_tready;
  assign lag_done  = (state == CORRELATE) && (cnt == CNT_LAST);

  // State register; reset aborts any operation back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode for the capture/correlate/report sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (beat) next_state = (CAP_LEN == 1) ? CORRELATE : CAPTURE;
      CAPTURE:   if (beat && cap_waddr == CAP_LAST) next_state = CORRELATE;
      CORRELATE: if (lag_done && lag == LAG_LAST) next_state = REPORT;
      REPORT:    if (handshake && last_beat) next_state = (ONESHOT != 0) ? HALT : IDLE;
      HALT:      if (arm) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Handshake and status flags registered from the upcoming state so they are 0 in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axis_tready <= 1'b0;
      ref_wready    <= 1'b0;
      s_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      s_axis_tready <= (next_state == IDLE) || (next_state == CAPTURE);
      ref_wready    <= (next_state == IDLE) || (next_state == CAPTURE) || (next_state == HALT);
      s_axis_tvalid <= (next_state == REPORT);
      busy          <= !((next_state == IDLE) || (next_state == HALT));
    end
  end

  // Capture write pointer; the first beat in IDLE lands at address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cap_waddr <= '0;
    else if (beat) cap_waddr <= (state == IDLE) ? CA_W'(1) : cap_waddr + CA_W'(1);
  end

  // Capture buffer write port
  always_ff @(posedge clk) begin
    if (beat) cap_mem[(state == IDLE) ? '0 : cap_waddr] <= m_axis_tdata;
  end

  // Reference buffer write port
  always_ff @(posedge clk) begin
    if (ref_we) ref_mem[ref_waddr] <= ref_wdata;
  end

  // Read addresses only meaningful during the issue cycles of a lag
  always_comb begin
    cap_raddr = '0;
    ref_raddr = '0;
    if (cnt < CNT_ISSUE) begin
      cap_raddr = CA_W'(lag) + CA_W'(cnt);
      ref_raddr = RA_W'(cnt);
    end
  end

  // Synchronous-read ports of both buffers
  always_ff @(posedge clk) begin
    cap_rdata <= cap_mem[cap_raddr];
    ref_rdata <= ref_mem[ref_raddr];
  end

  assign ci   = cap_rdata[DW-1:IQ_W];
  assign cq   = cap_rdata[IQ_W-1:0];
  assign ri   = ref_rdata[DW-1:IQ_W];
  assign rq   = ref_rdata[IQ_W-1:0];
  assign p_ii = DW'(ci) * DW'(ri);
  assign p_qq = DW'(cq) * DW'(rq);
  assign p_qi = DW'(cq) * DW'(ri);
  assign p_iq = DW'(ci) * DW'(rq);

  // Multiply stage: cap times conjugate of ref
  always_ff @(posedge clk) begin
    prod_re <= PW'(p_ii) + PW'(p_qq);
    prod_im <= PW'(p_qi) - PW'(p_iq);
  end

  // Accumulate stage; products of a lag arrive on counts 2..REF_LEN+1
  always_ff @(posedge clk) begin
    if (cnt >= CW'(2) && cnt <= CNT_ACC_END) begin
      if (cnt == CW'(2)) begin
        acc_re <= AW'(prod_re);
        acc_im <= AW'(prod_im);
      end else begin
        acc_re <= acc_re + AW'(prod_re);
        acc_im <= acc_im + AW'(prod_im);
      end
    end
  end

  assign sq_re    = MW'(acc_re) * MW'(acc_re);
  assign sq_im    = MW'(acc_im) * MW'(acc_im);
  assign mag_next = unsigned'(sq_re) + unsigned'(sq_im);

  // Magnitude stage, captured once the accumulator holds the full lag sum
  always_ff @(posedge clk) begin
    if (cnt == CNT_MAG) mag <= mag_next;
  end

  // Per-lag cycle counter, lag index and peak tracking (lowest lag wins ties)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      lag      <= '0;
      peak_mag <= '0;
      peak_lag <= '0;
    end else if (state != CORRELATE) begin
      cnt <= '0;
      lag <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      lag <= lag + 16'd1;
      if (lag == 16'd0 || mag > peak_mag) begin
        peak_mag <= mag;
        peak_lag <= lag;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef CAF_ALL_LAGS_EN
  localparam int LI_W = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;

  logic [15:0] lag_fifo [NUM_LAGS];
  logic [16:0] rd_ptr;

  // Lag result buffer filled during CORRELATE, drained in REPORT
  always_ff @(posedge clk) begin
    if (lag_done) lag_fifo[LI_W'(lag)] <= sat16(mag);
  end

  // Read pointer doubles as the lag number of the beat being offered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          rd_ptr <= '0;
    else if (state != REPORT)         rd_ptr <= '0;
    else if (handshake && !last_beat) rd_ptr <= rd_ptr + 17'd1;
  end

  assign last_beat = (rd_ptr == 17'(NUM_LAGS));

  // Result beat: per-lag entries first, then the peak
  always_comb begin
    s_axis_tdata = '0;
    if (s_axis_tvalid)
      s_axis_tdata = last_beat ? {peak_lag, sat16(peak_mag)}
                               : {rd_ptr[15:0], lag_fifo[LI_W'(rd_ptr)]};
  end
`else
  assign last_beat = 1'b1;

  // Result beat carries only the peak
  always_comb begin
    s_axis_tdata = '0;
    if (s_axis_tvalid) s_axis_tdata = {peak_lag, sat16(peak_mag)};
  end
`endif

  assign s_axis_tlast = s_axis_tvalid & last_beat;

endmodule

// File: tb/tb_caf_lag_correlator.sv
// Testbench for caf_lag_correlator: one auto-rearm and one ONESHOT instance driven in
// lockstep, expected beats from a behavioural correlation model held in a scoreboard.
`timescale 1ns/1ps
module tb_caf_lag_correlator;

  localparam int CAP_LEN  = 64;
  localparam int REF_LEN  = 16;
  localparam int NUM_LAGS = CAP_LEN - REF_LEN + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cap_data;
  logic        cap_valid;
  logic        ref_wen;
  logic [3:0]  ref_waddr;
  logic [15:0] ref_wdata;
  logic        arm;
  logic        res_ready;

  logic        tready0, wready0, tvalid0, tlast0, busy0;
  logic [31:0] tdata0;
  logic        tready1, wready1, tvalid1, tlast1, busy1;
  logic [31:0] tdata1;

  int    checks = 0;
  int    errors = 0;
  int    cap_i [CAP_LEN];
  int    cap_q [CAP_LEN];
  int    ref_i [REF_LEN];
  int    ref_q [REF_LEN];
  beat_t exp_q [$];

  caf_lag_correlator #(.IQ_W(8), .CAP_LEN(CAP_LEN), .REF_LEN(REF_LEN), .MAG_SHIFT(0), .ONESHOT(0)) dut0 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(cap_data), .m_axis_tvalid(cap_valid), .s_axis_tready(tready0),
    .ref_wen(ref_wen), .ref_waddr(ref_waddr), .ref_wdata(ref_wdata), .ref_wready(wready0),
    .arm(arm),
    .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0), .s_axis_tlast(tlast0),
    .m_axis_tready(res_ready), .busy(busy0)
  );

  caf_lag_correlator #(.IQ_W(8), .CAP_LEN(CAP_LEN), .REF_LEN(REF_LEN), .MAG_SHIFT(0), .ONESHOT(1)) dut1 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(cap_data), .m_axis_tvalid(cap_valid), .s_axis_tready(tready1),
    .ref_wen(ref_wen), .ref_waddr(ref_waddr), .ref_wdata(ref_wdata), .ref_wready(wready1),
    .arm(arm),
    .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast1),
    .m_axis_tready(res_ready), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] sat16(input longint m);
    return (m > 65535) ? 16'hFFFF : 16'(m);
  endfunction

  task automatic pushExpected();
    longint best, re, im, mag;
    int     best_lag;
    best = -1;
    best_lag = 0;
    for (int k = 0; k < NUM_LAGS; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < REF_LEN; n++) begin
        re += cap_i[k+n] * ref_i[n] + cap_q[k+n] * ref_q[n];
        im += cap_q[k+n] * ref_i[n] - cap_i[k+n] * ref_q[n];
      end
      mag = re * re + im * im;
`ifdef CAF_ALL_LAGS_EN
      exp_q.push_back('{data: {16'(k), sat16(mag)}, last: 1'b0});
`endif
      if (mag > best) begin
        best = mag;
        best_lag = k;
      end
    end
    exp_q.push_back('{data: {16'(best_lag), sat16(best)}, last: 1'b1});
  endtask

  task automatic fillCap(input int lo, input int hi, input int vi, input int vq);
    for (int i = 0; i < CAP_LEN; i++) begin
      cap_i[i] = (i >= lo && i <= hi) ? vi : 0;
      cap_q[i] = (i >= lo && i <= hi) ? vq : 0;
    end
  endtask

  task automatic fillRef(input int vi, input int vq);
    for (int n = 0; n < REF_LEN; n++) begin
      ref_i[n] = vi;
      ref_q[n] = vq;
    end
  endtask

  task automatic loadRef();
    for (int n = 0; n < REF_LEN; n++) begin
      ref_wen   = 1'b1;
      ref_waddr = 4'(n);
      ref_wdata = {8'(ref_i[n]), 8'(ref_q[n])};
      @(posedge clk); #1;
    end
    ref_wen = 1'b0;
  endtask

  task automatic rearm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic applyStimulus(input bit gaps, input bit ref_inline);
    int wait_cnt;
    for (int i = 0; i < CAP_LEN; i++) begin
      if (gaps && (i % 3 == 2)) begin
        cap_valid = 1'b0;
        @(posedge clk); #1;
      end
      cap_data  = {8'(cap_i[i]), 8'(cap_q[i])};
      cap_valid = 1'b1;
      if (ref_inline && i < REF_LEN) begin
        ref_wen   = 1'b1;
        ref_waddr = 4'(i);
        ref_wdata = {8'(ref_i[i]), 8'(ref_q[i])};
      end
      wait_cnt = 0;
      while (!tready0 && wait_cnt < 100) begin
        @(posedge clk); #1;
        wait_cnt++;
      end
      if (!tready0) begin
        checkOutput("capture_ready_timeout", tready0, 1);
        cap_valid = 1'b0;
        ref_wen   = 1'b0;
        return;
      end
      @(posedge clk); #1;
      ref_wen = 1'b0;
    end
    cap_valid = 1'b0;
    checkOutput("tready_drop_after_capture", tready0, 0);
    checkOutput("busy_in_correlate", busy0, 1);
    checkOutput("ref_wready_in_correlate", wready0, 0);
    pushExpected();
  endtask

  task automatic collectResult(input string tag, input int hold);
    int          budget;
    logic [31:0] snap;
    bit          stable, done;
    beat_t       e;
    res_ready = (hold == 0);
    budget = 0;
    while (!tvalid0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!tvalid0) begin
      checkOutput({tag, "_valid_timeout"}, tvalid0, 1);
      exp_q.delete();
      res_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      snap = tdata0;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!tvalid0 || tdata0 !== snap) stable = 1'b0;
      end
      checkOutput({tag, "_hold_stable"}, stable, 1);
      res_ready = 1'b1;
    end
    done = 1'b0;
    budget = 0;
    while (!done && budget < 1000) begin
      if (tvalid0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({tag, "_tdata"}, tdata0, e.data);
        checkOutput({tag, "_tlast"}, tlast0, e.last);
        checkOutput({tag, "_oneshot_tdata"}, tdata1, e.data);
        done = e.last;
      end
      @(posedge clk); #1;
      budget++;
    end
    if (!done) checkOutput({tag, "_drain_timeout"}, done, 1);
    checkOutput({tag, "_single_handshake"}, tvalid0, 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    cap_data = '0;
    cap_valid = 1'b0;
    ref_wen = 1'b0;
    ref_waddr = '0;
    ref_wdata = '0;
    arm = 1'b0;
    res_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_tready", tready0, 0);
    checkOutput("reset_tvalid", tvalid0, 0);
    checkOutput("reset_tdata", tdata0, 0);
    checkOutput("reset_tlast", tlast0, 0);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_wready", wready0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_tready", tready0, 1);
    checkOutput("idle_wready", wready0, 1);

    // Single pulse at lag 10
    $display("[TB] test 1: pulse correlation");
    fillRef(1, 0);
    fillCap(10, 25, 1, 0);
    loadRef();
    applyStimulus(1'b0, 1'b0);
    collectResult("t1", 0);

    // ONESHOT instance parks in HALT until arm
    $display("[TB] test 6: oneshot halt and arm");
    checkOutput("t6_autorearm_tready", tready0, 1);
    checkOutput("t6_halt_tready", tready1, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_halt_hold_tready", tready1, 0);
    checkOutput("t6_halt_busy", busy1, 0);
    checkOutput("t6_halt_wready", wready1, 1);
    rearm();
    checkOutput("t6_arm_tready", tready1, 1);

    // Conjugate check with an all-lags tie, capture with tvalid gaps
    $display("[TB] test 2: conjugate and tie");
    fillRef(0, 1);
    fillCap(0, CAP_LEN - 1, 0, 1);
    loadRef();
    applyStimulus(1'b1, 1'b0);
    collectResult("t2", 0);
    rearm();

    // Saturation, with reference written during capture
    $display("[TB] test 3: saturation");
    fillRef(127, 0);
    fillCap(0, CAP_LEN - 1, 127, 0);
    applyStimulus(1'b0, 1'b1);
    collectResult("t3", 0);
    rearm();

    // Backpressure on the result
    $display("[TB] test 4: result backpressure");
    fillRef(1, 0);
    fillCap(10, 25, 1, 0);
    loadRef();
    applyStimulus(1'b0, 1'b0);
    collectResult("t4", 50);
    rearm();

    // Reset in the middle of a capture
    $display("[TB] test 5: reset mid-capture");
    for (int i = 0; i < 30; i++) begin
      cap_data  = 16'($urandom);
      cap_valid = 1'b1;
      @(posedge clk); #1;
    end
    cap_valid = 1'b0;
    checkOutput("t5_busy_capture", busy0, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_reset_busy", busy0, 0);
    checkOutput("t5_reset_tready", tready0, 0);
    checkOutput("t5_reset_busy_oneshot", busy1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fillCap(30, 45, 1, 0);
    applyStimulus(1'b0, 1'b0);
    collectResult("t5", 0);
    rearm();

    // Random small-valued data
    $display("[TB] test 7: random data");
    for (int n = 0; n < REF_LEN; n++) begin
      ref_i[n] = int'($urandom_range(0, 15)) - 8;
      ref_q[n] = int'($urandom_range(0, 15)) - 8;
    end
    for (int i = 0; i < CAP_LEN; i++) begin
      cap_i[i] = int'($urandom_range(0, 15)) - 8;
      cap_q[i] = int'($urandom_range(0, 15)) - 8;
    end
    loadRef();
    applyStimulus(1'b1, 1'b0);
    collectResult("t7", 0);
    rearm();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
